serv_ctrl_w: RTL and testbench

Parametrised program-counter unit for the SERV family. It processes W bits per cycle (W ∈ {1,2,4,8}), so the same block serves bit-serial SERV and wider nibble/byte-serial variants. It owns the 32-bit fetch address and an internal beat counter. It computes sequential, jump, U-type and trap next-PC values, supplies return-address/AUIPC data to the register file, and flags misaligned jump targets. It sits between the state/decode logic and the instruction bus.

---
 rtl/serv_ctrl_w_pkg.sv | 19 +
 rtl/serv_ctrl_w_if.sv | 33 +++
 rtl/serv_ctrl_w_add.sv | 27 ++
 rtl/serv_ctrl_w.sv | 119 +++++++++++
 tb/tb_serv_ctrl_w.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serv_ctrl_w_pkg.sv
// Shared constants and types for the W-bit-per-cycle SERV program-counter unit.
// Legal slice widths are 1, 2, 4 and 8 bits; an update takes 32/W beats.
package serv_ctrl_w_pkg;

  localparam logic [31:0] INC4      = 32'd4;
  localparam logic [31:0] INC2      = 32'd2;
  localparam logic [31:0] UIMM_MASK = 32'hffff_f000;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_JUMP = 2'd1,
    SEL_TRAP = 2'd2
  } next_sel_e;

  function automatic int beats(input int w);
    return 32 / w;
  endfunction

endpackage

// File: rtl/serv_ctrl_w_if.sv
// Bus between state/decode logic and the program-counter unit, W bits per beat.
interface serv_ctrl_w_if #(
  parameter int W = 1
);
  // i_pc_en acts as a valid with no ready: every cycle it is high the unit
  // consumes the current operand slices and advances one beat.
  logic         i_pc_en;
  logic         i_jump;
  logic         i_jal_or_jalr;
  logic         i_utype;
  logic         i_pc_rel;
  logic         i_trap;
  logic         i_iscomp;
  logic [W-1:0] i_imm;
  logic [W-1:0] i_buf;
  logic [W-1:0] i_csr_pc;
  logic [W-1:0] o_rd;
  logic         o_bad_pc;
  logic         o_done;
  logic [31:0]  o_ibus_adr;

  modport slave (
    input  i_pc_en, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp,
    input  i_imm, i_buf, i_csr_pc,
    output o_rd, o_bad_pc, o_done, o_ibus_adr
  );

  modport master (
    output i_pc_en, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp,
    output i_imm, i_buf, i_csr_pc,
    input  o_rd, o_bad_pc, o_done, o_ibus_adr
  );
endinterface

// File: rtl/serv_ctrl_w_add.sv
// W-bit slice adder whose carry ripples between beats through a register.
// The carry is dropped after the last beat so the next update starts clean.
module serv_ser_add #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q
);
  logic         cy_r;
  logic [W:0]   sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cy_r};
  assign q   = sum[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cy_r <= 1'b0;
    end else if (en) begin
      cy_r <= clr ? 1'b0 : sum[W];
    end
  end
endmodule

// File: rtl/serv_ctrl_w.sv
// Program-counter unit: builds the next fetch address W bits per beat, LSB first,
// shifting it into o_ibus_adr while producing rd data and a misalignment flag.
module serv_ctrl_w
  import serv_ctrl_w_pkg::*;
#(
  parameter int          W        = 1,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter bit          WITH_CSR = 1'b1,
  parameter bit          WITH_C   = 1'b1
) (
  input  logic               clk,
  input  logic               i_rst_n,
  serv_ctrl_w_if.slave       bus
);
  localparam int B       = beats(W);
  localparam int KW      = (B > 1) ? $clog2(B) : 1;
  // Address bit 1 lives in beat 0 unless slices are a single bit wide.
  localparam int BIT1_K   = (W >= 2) ? 0 : 1;
  localparam int BIT1_IDX = (W >= 2) ? 1 : 0;

  logic [KW-1:0] k;
  logic          last;
  logic [31:0]   adr;
  logic          bad_pc;
  logic          done;

  logic [W-1:0]  pc;
  logic [W-1:0]  inc_k;
  logic [W-1:0]  umask_k;
  logic [W-1:0]  ob;
  logic [W-1:0]  off_a;
  logic [W-1:0]  s4;
  logic [W-1:0]  so;
  logic [W-1:0]  aligned;
  logic [W-1:0]  csr_slice;
  logic [W-1:0]  new_slice;
  logic [31:0]   inc_word;
  next_sel_e     sel;

  assign last  = (k == KW'(B - 1));
  assign pc    = adr[W-1:0];

  always_comb begin
    inc_word  = (WITH_C && bus.i_iscomp) ? INC2 : INC4;
    inc_k     = W'(inc_word >> (int'(k) * W));
    umask_k   = W'(UIMM_MASK >> (int'(k) * W));
    ob        = bus.i_utype ? (bus.i_imm & umask_k) : bus.i_buf;
    off_a     = bus.i_pc_rel ? pc : '0;
  end

  serv_ser_add #(.W(W)) u_seq_add (
    .clk   (clk),
    .rst_n (i_rst_n),
    .en    (bus.i_pc_en),
    .clr   (last),
    .a     (pc),
    .b     (inc_k),
    .q     (s4)
  );

  serv_ser_add #(.W(W)) u_off_add (
    .clk   (clk),
    .rst_n (i_rst_n),
    .en    (bus.i_pc_en),
    .clr   (last),
    .a     (off_a),
    .b     (ob),
    .q     (so)
  );

  always_comb begin
    aligned   = so;
    csr_slice = bus.i_csr_pc;
    if (k == '0) begin
      aligned[0]   = 1'b0;
      csr_slice[0] = 1'b0;
    end
    sel = SEL_SEQ;
    if (WITH_CSR && bus.i_trap) begin
      sel = SEL_TRAP;
    end else if (bus.i_jump) begin
      sel = SEL_JUMP;
    end
    case (sel)
      SEL_TRAP: new_slice = csr_slice;
      SEL_JUMP: new_slice = aligned;
      default:  new_slice = s4;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k      <= '0;
      adr    <= RESET_PC;
      bad_pc <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= bus.i_pc_en & last;
      if (bus.i_pc_en) begin
        k   <= last ? '0 : k + KW'(1);
        adr <= {new_slice, adr[31:W]};
        if (k == '0) begin
          bad_pc <= 1'b0;
        end
        // Load after the clear so that for W>=2 the fresh value wins in beat 0.
        if (k == KW'(BIT1_K)) begin
          bad_pc <= aligned[BIT1_IDX] & bus.i_jump & ~WITH_C;
        end
      end
    end
  end

  assign bus.o_rd       = bus.i_pc_en ? ((bus.i_utype ? aligned : '0) |
                                         (bus.i_jal_or_jalr ? s4 : '0)) : '0;
  assign bus.o_bad_pc   = bad_pc;
  assign bus.o_done     = done;
  assign bus.o_ibus_adr = adr;

endmodule

// File: tb/tb_serv_ctrl_w.sv
// Directed bench for serv_ctrl_w: four instances (W=1,2,4,8) share operand words,
// only the selected one is enabled; the bench slices operands per beat itself.
module tb_serv_ctrl_w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  int          sel;
  int          beat;
  logic        jump, jal, utype, pc_rel, trap, iscomp;
  logic [31:0] imm_full, buf_full, csr_full;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  serv_ctrl_w_if #(.W(1)) bus1();
  serv_ctrl_w_if #(.W(2)) bus2();
  serv_ctrl_w_if #(.W(4)) bus4();
  serv_ctrl_w_if #(.W(8)) bus8();

  serv_ctrl_w #(.W(1), .RESET_PC(32'h1fe), .WITH_CSR(1'b1), .WITH_C(1'b1))
    dut1 (.clk(clk), .i_rst_n(rst_n), .bus(bus1));
  serv_ctrl_w #(.W(2), .RESET_PC(32'h0), .WITH_CSR(1'b1), .WITH_C(1'b0))
    dut2 (.clk(clk), .i_rst_n(rst_n), .bus(bus2));
  serv_ctrl_w #(.W(4), .RESET_PC(32'h100), .WITH_CSR(1'b1), .WITH_C(1'b1))
    dut4 (.clk(clk), .i_rst_n(rst_n), .bus(bus4));
  serv_ctrl_w #(.W(8), .RESET_PC(32'h100), .WITH_CSR(1'b1), .WITH_C(1'b1))
    dut8 (.clk(clk), .i_rst_n(rst_n), .bus(bus8));

  // Shared controls, per-width operand slicing
  assign bus1.i_pc_en = en && (sel == 1);
  assign bus2.i_pc_en = en && (sel == 2);
  assign bus4.i_pc_en = en && (sel == 4);
  assign bus8.i_pc_en = en && (sel == 8);
  assign bus1.i_jump = jump;   assign bus2.i_jump = jump;
  assign bus4.i_jump = jump;   assign bus8.i_jump = jump;
  assign bus1.i_jal_or_jalr = jal;  assign bus2.i_jal_or_jalr = jal;
  assign bus4.i_jal_or_jalr = jal;  assign bus8.i_jal_or_jalr = jal;
  assign bus1.i_utype = utype;  assign bus2.i_utype = utype;
  assign bus4.i_utype = utype;  assign bus8.i_utype = utype;
  assign bus1.i_pc_rel = pc_rel;  assign bus2.i_pc_rel = pc_rel;
  assign bus4.i_pc_rel = pc_rel;  assign bus8.i_pc_rel = pc_rel;
  assign bus1.i_trap = trap;  assign bus2.i_trap = trap;
  assign bus4.i_trap = trap;  assign bus8.i_trap = trap;
  assign bus1.i_iscomp = iscomp;  assign bus2.i_iscomp = iscomp;
  assign bus4.i_iscomp = iscomp;  assign bus8.i_iscomp = iscomp;
  assign bus1.i_imm = 1'(imm_full >> beat);
  assign bus2.i_imm = 2'(imm_full >> (beat * 2));
  assign bus4.i_imm = 4'(imm_full >> (beat * 4));
  assign bus8.i_imm = 8'(imm_full >> (beat * 8));
  assign bus1.i_buf = 1'(buf_full >> beat);
  assign bus2.i_buf = 2'(buf_full >> (beat * 2));
  assign bus4.i_buf = 4'(buf_full >> (beat * 4));
  assign bus8.i_buf = 8'(buf_full >> (beat * 8));
  assign bus1.i_csr_pc = 1'(csr_full >> beat);
  assign bus2.i_csr_pc = 2'(csr_full >> (beat * 2));
  assign bus4.i_csr_pc = 4'(csr_full >> (beat * 4));
  assign bus8.i_csr_pc = 8'(csr_full >> (beat * 8));

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cur_rd(input int w);
    case (w)
      1:       return {31'b0, bus1.o_rd};
      2:       return {30'b0, bus2.o_rd};
      4:       return {28'b0, bus4.o_rd};
      default: return {24'b0, bus8.o_rd};
    endcase
  endfunction

  function automatic logic cur_done(input int w);
    case (w)
      1:       return bus1.o_done;
      2:       return bus2.o_done;
      4:       return bus4.o_done;
      default: return bus8.o_done;
    endcase
  endfunction

  function automatic logic cur_bad(input int w);
    case (w)
      1:       return bus1.o_bad_pc;
      2:       return bus2.o_bad_pc;
      4:       return bus4.o_bad_pc;
      default: return bus8.o_bad_pc;
    endcase
  endfunction

  // Driver tasks
  task automatic set_ctrl(input logic j, input logic jl, input logic u, input logic rel,
                          input logic tr, input logic c, input logic [31:0] imm,
                          input logic [31:0] bf, input logic [31:0] csr);
    jump = j; jal = jl; utype = u; pc_rel = rel; trap = tr; iscomp = c;
    imm_full = imm; buf_full = bf; csr_full = csr;
  endtask

  // One update on instance w. Cycle 1 is the first enabled beat. Optional pause of
  // pause_len cycles at beat pause_at, or reset asserted (and left low) at rst_at.
  task automatic run_update(input int w, input int pause_at, input int pause_len,
                            input int rst_at, output logic [31:0] rd_acc,
                            output int done_cyc, output int done_cnt, output logic bad2);
    int b;
    int k;
    int cyc;
    int paused;
    bit aborted;
    b = 32 / w; k = 0; cyc = 0; paused = 0; aborted = 0;
    rd_acc = '0; done_cyc = -1; done_cnt = 0; bad2 = 1'bx;
    sel = w;
    while (cyc < b + pause_len + 4) begin
      @(negedge clk);
      cyc++;
      if (cur_done(w)) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 2) bad2 = cur_bad(w);
      if (aborted || k >= b) begin
        en = 1'b0;
      end else if (k == rst_at) begin
        rst_n = 1'b0;
        en = 1'b0;
        aborted = 1;
      end else if (k == pause_at && paused < pause_len) begin
        en = 1'b0;
        paused++;
      end else begin
        beat = k;
        en = 1'b1;
        #1;
        rd_acc = rd_acc | (cur_rd(w) << (k * w));
        k++;
      end
    end
    en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus and scoreboard
  initial begin
    logic [31:0] rd;
    int          dc;
    int          dn;
    logic        b2;

    rst_n = 1'b0; en = 1'b0; sel = 0; beat = 0;
    set_ctrl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    #12;
    check("rst_adr_w1", bus1.o_ibus_adr, 32'h1fe);
    check("rst_adr_w2", bus2.o_ibus_adr, 32'h0);
    check("rst_adr_w4", bus4.o_ibus_adr, 32'h100);
    check("rst_adr_w8", bus8.o_ibus_adr, 32'h100);
    check("rst_done_w4", {31'b0, bus4.o_done}, 32'h0);
    check("rst_bad_w2", {31'b0, bus2.o_bad_pc}, 32'h0);
    check("rst_rd_w8", {24'b0, bus8.o_rd}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // W=4 sequential from 0x100
    exp_q.push_back(32'h104);
    run_update(4, -1, 0, -1, rd, dc, dn, b2);
    check("w4_seq_adr", bus4.o_ibus_adr, exp_q.pop_front());
    check("w4_seq_done_cyc", 32'(dc), 32'd9);
    check("w4_seq_done_cnt", 32'(dn), 32'd1);
    check("w4_seq_rd", rd, 32'h0);

    // W=1 compressed increment, carry across several beats
    set_ctrl(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    exp_q.push_back(32'h200);
    run_update(1, -1, 0, -1, rd, dc, dn, b2);
    check("w1_comp_adr", bus1.o_ibus_adr, exp_q.pop_front());
    check("w1_comp_done_cyc", 32'(dc), 32'd33);

    // W=8 JAL, PC-relative, negative offset
    set_ctrl(1, 1, 0, 1, 0, 0, 32'h0, 32'hffff_fff0, 32'h0);
    exp_q.push_back(32'h0000_00f0);
    run_update(8, -1, 0, -1, rd, dc, dn, b2);
    check("w8_jal_adr", bus8.o_ibus_adr, exp_q.pop_front());
    check("w8_jal_rd", rd, 32'h104);
    check("w8_jal_bad", {31'b0, bus8.o_bad_pc}, 32'h0);
    check("w8_jal_done_cyc", 32'(dc), 32'd5);

    // W=8 AUIPC from 0xF0: low 12 immediate bits ignored
    set_ctrl(0, 0, 1, 1, 0, 0, 32'h1234_5678, 32'h0, 32'h0);
    exp_q.push_back(32'h0000_00f4);
    run_update(8, -1, 0, -1, rd, dc, dn, b2);
    check("w8_auipc_adr", bus8.o_ibus_adr, exp_q.pop_front());
    check("w8_auipc_rd", rd, 32'h1234_50f0);

    // W=2 without compressed support: jump to 0x102 is misaligned
    set_ctrl(1, 0, 0, 0, 0, 0, 32'h0, 32'h102, 32'h0);
    exp_q.push_back(32'h102);
    run_update(2, -1, 0, -1, rd, dc, dn, b2);
    check("w2_jmp_adr", bus2.o_ibus_adr, exp_q.pop_front());
    check("w2_jmp_bad_c2", {31'b0, b2}, 32'h1);
    check("w2_jmp_bad_hold", {31'b0, bus2.o_bad_pc}, 32'h1);
    set_ctrl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    exp_q.push_back(32'h106);
    run_update(2, -1, 0, -1, rd, dc, dn, b2);
    check("w2_seq_adr", bus2.o_ibus_adr, exp_q.pop_front());
    check("w2_seq_bad_c2", {31'b0, b2}, 32'h0);

    // W=4 trap together with jump: trap wins, bit 0 cleared
    set_ctrl(1, 0, 0, 1, 1, 0, 32'h0, 32'h0000_0040, 32'h8000_0001);
    exp_q.push_back(32'h8000_0000);
    run_update(4, -1, 0, -1, rd, dc, dn, b2);
    check("w4_trap_adr", bus4.o_ibus_adr, exp_q.pop_front());
    check("w4_trap_bad", {31'b0, bus4.o_bad_pc}, 32'h0);

    // W=4 pause of two cycles at beat 3
    apply_reset();
    set_ctrl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    exp_q.push_back(32'h104);
    run_update(4, 3, 2, -1, rd, dc, dn, b2);
    check("w4_pause_adr", bus4.o_ibus_adr, exp_q.pop_front());
    check("w4_pause_done_cyc", 32'(dc), 32'd11);
    check("w4_pause_done_cnt", 32'(dn), 32'd1);

    // W=4 reset at beat 5 abandons the update
    apply_reset();
    run_update(4, -1, 0, 5, rd, dc, dn, b2);
    check("w4_rst_adr", bus4.o_ibus_adr, 32'h100);
    check("w4_rst_done_cnt", 32'(dn), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h104);
    run_update(4, -1, 0, -1, rd, dc, dn, b2);
    check("w4_after_rst_adr", bus4.o_ibus_adr, exp_q.pop_front());
    check("w4_after_rst_done_cyc", 32'(dc), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
